// File: rtl/csr_file.sv
// Machine/supervisor CSR file and trap unit at commit. Executes CSR ops, ECALL,
// MRET and SRET, takes the machine-timer interrupt and issues a one-cycle redirect.
module csr_file #(
    parameter int          XLEN   = 64,
    parameter bit          HAS_S  = 1'b1,
    parameter logic [63:0] HARTID = 64'd0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid,
    input  logic [2:0]      op,
    input  logic [11:0]     addr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] wdata,
    input  logic            irq_mtip,
    output logic [XLEN-1:0] rdata,
    output logic            r_valid,
    output logic            illegal,
    output logic [XLEN-1:0] satp,
    output logic [1:0]      priv_o,
    output logic            trap_en,
    output logic [XLEN-1:0] trap_pc
);
    localparam logic [2:0] OP_CSRW = 3'd1, OP_CSRS = 3'd2, OP_CSRC = 3'd3;
    localparam logic [2:0] OP_ECALL = 3'd4, OP_MRET = 3'd5, OP_SRET = 3'd6;
    localparam logic [1:0] PRIV_U = 2'd0, PRIV_S = 2'd1, PRIV_M = 2'd3;
    localparam logic [63:0] MSTATUS_MASK = 64'h0000_0000_0000_19AA;
    localparam logic [63:0] SSTATUS_MASK = 64'h0000_0000_0000_0122;
    localparam logic [63:0] MISA_VAL = 64'h8000_0000_0010_1100 | (HAS_S ? 64'h4_0000 : 64'h0);

    logic [1:0]      priv_q, priv_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d, medeleg_q, medeleg_d, mie_q, mie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d, mtval_q, mtval_d;
    logic [XLEN-1:0] stvec_q, stvec_d, sscratch_q, sscratch_d, sepc_q, sepc_d;
    logic [XLEN-1:0] scause_q, scause_d, stval_q, stval_d, satp_q, satp_d;
    logic [XLEN-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic            trap_en_q, trap_en_d;
    logic [XLEN-1:0] trap_pc_q, trap_pc_d;

    logic            csr_hit, csr_bad, is_csr, mret_bad, sret_bad;
    logic            irq_take, exc, deleg, mret_do, sret_do, csr_we;
    logic [5:0]      exc_code;
    logic [XLEN-1:0] csr_rd, wval;

    function automatic logic [63:0] vec_target(input logic [63:0] tvec, input logic intr,
                                               input logic [63:0] cause);
        vec_target = {tvec[63:2], 2'b00} + ((tvec[0] && intr) ? {cause[61:0], 2'b00} : 64'd0);
    endfunction

    // Unsupported MPP encodings collapse to U.
    function automatic logic [63:0] mstatus_legal(input logic [63:0] v);
        logic [63:0] r;
        r = v & MSTATUS_MASK;
        if (r[12:11] == 2'b10 || (!HAS_S && r[12:11] == 2'b01)) r[12:11] = 2'b00;
        return r;
    endfunction

    always_comb begin
        csr_hit = 1'b1;
        csr_rd  = '0;
        case (addr)
            12'h100: begin csr_hit = HAS_S; csr_rd = mstatus_q & SSTATUS_MASK; end
            12'h105: begin csr_hit = HAS_S; csr_rd = stvec_q;    end
            12'h140: begin csr_hit = HAS_S; csr_rd = sscratch_q; end
            12'h141: begin csr_hit = HAS_S; csr_rd = sepc_q;     end
            12'h142: begin csr_hit = HAS_S; csr_rd = scause_q;   end
            12'h143: begin csr_hit = HAS_S; csr_rd = stval_q;    end
            12'h180: begin csr_hit = HAS_S; csr_rd = satp_q;     end
            12'h300: csr_rd = mstatus_q;
            12'h301: csr_rd = MISA_VAL;
            12'h302: csr_rd = medeleg_q;
            12'h304: csr_rd = mie_q;
            12'h305: csr_rd = mtvec_q;
            12'h340: csr_rd = mscratch_q;
            12'h341: csr_rd = mepc_q;
            12'h342: csr_rd = mcause_q;
            12'h343: csr_rd = mtval_q;
            12'h344: csr_rd = {56'd0, irq_mtip, 7'd0};
            12'hB00: csr_rd = mcycle_q;
            12'hB02: csr_rd = minstret_q;
            12'hC00: csr_rd = mcycle_q;
            12'hF14: csr_rd = HARTID;
            default: csr_hit = 1'b0;
        endcase
    end

    assign is_csr   = (op == OP_CSRW) || (op == OP_CSRS) || (op == OP_CSRC);
    assign csr_bad  = !csr_hit || (addr[9:8] > priv_q) || (addr[11:10] == 2'b11);
    assign mret_bad = (priv_q != PRIV_M);
    assign sret_bad = !HAS_S || (priv_q == PRIV_U);
    assign illegal  = valid && ((is_csr && csr_bad) || (op == OP_MRET && mret_bad) ||
                                (op == OP_SRET && sret_bad));
    assign r_valid  = valid && is_csr && !csr_bad;
    assign rdata    = r_valid ? csr_rd : '0;

    // The interrupt pre-empts whatever instruction is committing.
    assign irq_take = valid && irq_mtip && mie_q[7] && (priv_q != PRIV_M || mstatus_q[3]);
    assign exc      = valid && !irq_take && (illegal || op == OP_ECALL);
    assign exc_code = illegal ? 6'd2 : (priv_q == PRIV_U) ? 6'd8 : (priv_q == PRIV_S) ? 6'd9 : 6'd11;
    assign deleg    = HAS_S && medeleg_q[exc_code] && (priv_q != PRIV_M);
    assign mret_do  = valid && !irq_take && op == OP_MRET && !mret_bad;
    assign sret_do  = valid && !irq_take && op == OP_SRET && !sret_bad;
    assign csr_we   = r_valid && !irq_take;

    always_comb begin
        case (op)
            OP_CSRS: wval = csr_rd | wdata;
            OP_CSRC: wval = csr_rd & ~wdata;
            default: wval = wdata;
        endcase
    end

    always_comb begin
        priv_d = priv_q;       mstatus_d = mstatus_q;   medeleg_d = medeleg_q;
        mie_d = mie_q;         mtvec_d = mtvec_q;       mscratch_d = mscratch_q;
        mepc_d = mepc_q;       mcause_d = mcause_q;     mtval_d = mtval_q;
        stvec_d = stvec_q;     sscratch_d = sscratch_q; sepc_d = sepc_q;
        scause_d = scause_q;   stval_d = stval_q;       satp_d = satp_q;
        trap_en_d = 1'b0;      trap_pc_d = trap_pc_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = (valid && op != OP_ECALL && !exc && !irq_take) ? minstret_q + 64'd1 : minstret_q;
        if (csr_we) begin
            case (addr)
                12'h100: mstatus_d  = (mstatus_q & ~SSTATUS_MASK) | (wval & SSTATUS_MASK);
                12'h105: stvec_d    = wval;
                12'h140: sscratch_d = wval;
                12'h141: sepc_d     = wval;
                12'h142: scause_d   = wval;
                12'h143: stval_d    = wval;
                12'h180: satp_d     = wval;
                12'h300: mstatus_d  = mstatus_legal(wval);
                12'h302: medeleg_d  = HAS_S ? wval : '0;
                12'h304: mie_d      = wval;
                12'h305: mtvec_d    = wval;
                12'h340: mscratch_d = wval;
                12'h341: mepc_d     = wval;
                12'h342: mcause_d   = wval;
                12'h343: mtval_d    = wval;
                12'hB00: mcycle_d   = wval;
                12'hB02: minstret_d = wval;
                default: ;
            endcase
        end
        if (irq_take || (exc && !deleg)) begin
            mepc_d        = pc;
            mcause_d      = irq_take ? {1'b1, 63'd7} : {58'd0, exc_code};
            mtval_d       = '0;
            mstatus_d[12:11] = priv_q;
            mstatus_d[7]  = mstatus_q[3];
            mstatus_d[3]  = 1'b0;
            priv_d        = PRIV_M;
            trap_en_d     = 1'b1;
            trap_pc_d     = vec_target(mtvec_q, irq_take, 64'd7);
        end else if (exc) begin
            sepc_d        = pc;
            scause_d      = {58'd0, exc_code};
            stval_d       = '0;
            mstatus_d[8]  = priv_q[0];
            mstatus_d[5]  = mstatus_q[1];
            mstatus_d[1]  = 1'b0;
            priv_d        = PRIV_S;
            trap_en_d     = 1'b1;
            trap_pc_d     = vec_target(stvec_q, 1'b0, 64'd0);
        end else if (mret_do) begin
            priv_d        = mstatus_q[12:11];
            mstatus_d[3]  = mstatus_q[7];
            mstatus_d[7]  = 1'b1;
            mstatus_d[12:11] = PRIV_U;
            trap_en_d     = 1'b1;
            trap_pc_d     = mepc_q;
        end else if (sret_do) begin
            priv_d        = {1'b0, mstatus_q[8]};
            mstatus_d[1]  = mstatus_q[5];
            mstatus_d[5]  = 1'b1;
            mstatus_d[8]  = 1'b0;
            trap_en_d     = 1'b1;
            trap_pc_d     = sepc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            priv_q <= PRIV_M;    mstatus_q <= '0;  medeleg_q <= '0;  mie_q <= '0;
            mtvec_q <= '0;       mscratch_q <= '0; mepc_q <= '0;     mcause_q <= '0;
            mtval_q <= '0;       stvec_q <= '0;    sscratch_q <= '0; sepc_q <= '0;
            scause_q <= '0;      stval_q <= '0;    satp_q <= '0;     mcycle_q <= '0;
            minstret_q <= '0;    trap_en_q <= 1'b0; trap_pc_q <= '0;
        end else begin
            priv_q <= priv_d;     mstatus_q <= mstatus_d;   medeleg_q <= medeleg_d;
            mie_q <= mie_d;       mtvec_q <= mtvec_d;       mscratch_q <= mscratch_d;
            mepc_q <= mepc_d;     mcause_q <= mcause_d;     mtval_q <= mtval_d;
            stvec_q <= stvec_d;   sscratch_q <= sscratch_d; sepc_q <= sepc_d;
            scause_q <= scause_d; stval_q <= stval_d;       satp_q <= satp_d;
            mcycle_q <= mcycle_d; minstret_q <= minstret_d;
            trap_en_q <= trap_en_d; trap_pc_q <= trap_pc_d;
        end
    end

    assign satp    = satp_q;
    assign priv_o  = priv_q;
    assign trap_en = trap_en_q;
    assign trap_pc = trap_pc_q;
endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: reset state, CSR access, traps, delegation,
// interrupt vectoring, returns, counter wrap and asynchronous reset.
module tb_csr_file;
    localparam logic [2:0] NONE = 3'd0, CSRW = 3'd1, CSRS = 3'd2, CSRC = 3'd3;
    localparam logic [2:0] ECALL = 3'd4, MRET = 3'd5, SRET = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [2:0]  op;
    logic [11:0] addr;
    logic [63:0] pc, wdata;
    logic        irq_mtip;
    logic [63:0] rdata, satp, trap_pc;
    logic        r_valid, illegal, trap_en;
    logic [1:0]  priv_o;

    int checks = 0;
    int errors = 0;

    csr_file #(.XLEN(64), .HAS_S(1'b1), .HARTID(64'd0)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .op(op), .addr(addr), .pc(pc),
        .wdata(wdata), .irq_mtip(irq_mtip), .rdata(rdata), .r_valid(r_valid),
        .illegal(illegal), .satp(satp), .priv_o(priv_o), .trap_en(trap_en),
        .trap_pc(trap_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [2:0] o, input logic [11:0] a, input logic [63:0] w,
                      input logic [63:0] p);
        valid = 1'b1; op = o; addr = a; wdata = w; pc = p;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        valid = 1'b0; op = NONE; addr = '0; wdata = '0; pc = '0;
    endtask

    task automatic wr(input logic [2:0] o, input logic [11:0] a, input logic [63:0] w);
        go(o, a, w, 64'h0);
        tick();
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] exp);
        go(CSRS, a, 64'h0, 64'h0);
        chk(tag, rdata, exp);
        tick();
    endtask

    task automatic redirect(input string tag, input logic [63:0] tpc, input logic [1:0] pv);
        tick();
        chk({tag, "_en"}, {63'd0, trap_en}, 64'd1);
        chk({tag, "_pc"}, trap_pc, tpc);
        chk({tag, "_priv"}, {62'd0, priv_o}, {62'd0, pv});
        tick();
        chk({tag, "_pulse"}, {63'd0, trap_en}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; op = NONE; addr = '0; wdata = '0; pc = '0; irq_mtip = 1'b0;
        #12;
        chk("rst_priv", {62'd0, priv_o}, 64'd3);
        chk("rst_trap_en", {63'd0, trap_en}, 64'd0);
        chk("rst_trap_pc", trap_pc, 64'd0);
        chk("rst_satp", satp, 64'd0);
        rst_n = 1'b1;

        // misa readback and a legal read handshake
        go(CSRS, 12'h301, 64'h0, 64'h0);
        chk("misa", rdata, 64'h8000_0000_0014_1100);
        chk("misa_rvalid", {63'd0, r_valid}, 64'd1);
        chk("misa_illegal", {63'd0, illegal}, 64'd0);
        tick();

        // ECALL from M
        wr(CSRW, 12'h305, 64'h8000_0000);
        go(ECALL, 12'h0, 64'h0, 64'h100);
        redirect("ecall_m", 64'h8000_0000, 2'd3);
        rd("ecall_mcause", 12'h342, 64'd11);
        rd("ecall_mepc", 12'h341, 64'h100);
        rd("ecall_mstatus", 12'h300, 64'h1800);

        // MRET to U, then an illegal M access from U
        wr(CSRC, 12'h300, 64'h1800);
        wr(CSRW, 12'h341, 64'h200);
        go(MRET, 12'h0, 64'h0, 64'h0);
        redirect("mret_u", 64'h200, 2'd0);
        go(CSRW, 12'h300, 64'hFFFF, 64'h300);
        chk("u_illegal", {63'd0, illegal}, 64'd1);
        chk("u_rvalid", {63'd0, r_valid}, 64'd0);
        chk("u_rdata", rdata, 64'd0);
        redirect("u_trap", 64'h8000_0000, 2'd3);
        rd("u_mcause", 12'h342, 64'd2);
        rd("u_mepc", 12'h341, 64'h300);
        rd("u_mstatus", 12'h300, 64'h0);

        // ECALL from U delegated to S
        wr(CSRW, 12'h302, 64'h100);
        wr(CSRW, 12'h105, 64'h4000);
        wr(CSRW, 12'h300, 64'h2);
        wr(CSRW, 12'h341, 64'h500);
        go(MRET, 12'h0, 64'h0, 64'h0);
        redirect("mret_u2", 64'h500, 2'd0);
        go(ECALL, 12'h0, 64'h0, 64'h600);
        redirect("deleg", 64'h4000, 2'd1);
        rd("deleg_scause", 12'h142, 64'd8);
        rd("deleg_sepc", 12'h141, 64'h600);
        rd("deleg_sstatus", 12'h100, 64'h20);

        // ECALL from S is not delegated
        go(ECALL, 12'h0, 64'h0, 64'h700);
        redirect("ecall_s", 64'h8000_0000, 2'd3);
        rd("ecall_s_mcause", 12'h342, 64'd9);
        rd("ecall_s_mstatus", 12'h300, 64'h820);

        // SRET from M, then MRET from S is illegal
        wr(CSRW, 12'h141, 64'h700);
        wr(CSRS, 12'h300, 64'h120);
        go(SRET, 12'h0, 64'h0, 64'h0);
        redirect("sret", 64'h700, 2'd1);
        go(MRET, 12'h0, 64'h0, 64'h800);
        chk("mret_s_illegal", {63'd0, illegal}, 64'd1);
        redirect("mret_s_trap", 64'h8000_0000, 2'd3);
        rd("mret_s_mcause", 12'h342, 64'd2);
        rd("mret_s_mepc", 12'h341, 64'h800);

        // Vectored timer interrupt pre-empts a CSRW
        wr(CSRW, 12'h305, 64'h1001);
        wr(CSRW, 12'h304, 64'h80);
        wr(CSRS, 12'h300, 64'h8);
        irq_mtip = 1'b1;
        go(CSRW, 12'h340, 64'hDEAD, 64'h900);
        redirect("irq", 64'h101C, 2'd3);
        rd("irq_mip", 12'h344, 64'h80);
        irq_mtip = 1'b0;
        rd("irq_mcause", 12'h342, 64'h8000_0000_0000_0007);
        rd("irq_mscratch", 12'h340, 64'h0);
        rd("irq_mepc", 12'h341, 64'h900);
        rd("irq_mstatus", 12'h300, 64'h18A2);
        go(ECALL, 12'h0, 64'h0, 64'hA00);
        redirect("exc_novec", 64'h1000, 2'd3);

        // Counters, read-only space, MPP legalisation
        wr(CSRW, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        rd("mcycle_wrap", 12'hB00, 64'h0);
        wr(CSRW, 12'hB02, 64'd5);
        wr(NONE, 12'h0, 64'h0);
        rd("minstret", 12'hB02, 64'd6);
        go(CSRS, 12'hC00, 64'h0, 64'hB00);
        chk("cycle_ro_illegal", {63'd0, illegal}, 64'd1);
        chk("cycle_ro_rdata", rdata, 64'd0);
        redirect("cycle_ro_trap", 64'h1000, 2'd3);
        wr(CSRW, 12'h300, 64'h1000);
        rd("mpp_legal", 12'h300, 64'h0);
        wr(CSRW, 12'h180, 64'h1234);
        chk("satp_out", satp, 64'h1234);

        // Asynchronous reset kills a pending redirect
        go(ECALL, 12'h0, 64'h0, 64'hC00);
        tick();
        chk("pre_rst_en", {63'd0, trap_en}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_en", {63'd0, trap_en}, 64'd0);
        chk("async_rst_pc", trap_pc, 64'd0);
        chk("async_rst_satp", satp, 64'd0);
        #20;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/csr_file.md
# csr_file

Parametrised machine/supervisor CSR file and trap unit at the commit stage of the core pipeline. It holds an explicit set of privileged CSRs and tracks the current privilege level (M/S/U). It executes CSR read/write/set/clear, ECALL, MRET and SRET, and checks each access for legality. It takes machine-timer interrupts, delegates exceptions to S-mode through `medeleg`, and emits a one-cycle redirect to the fetch unit.

## Interface
- `XLEN`, 64: data width; only 64 is supported.
- `HAS_S`, 1: S-mode present; when 0, every S-mode CSR, SRET and S delegation is illegal, and `medeleg` reads 0.
- `HARTID`, 0: value returned by `mhartid`.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid`  in  1  a committing instruction is present this cycle.
- `op`  in  3  operation: 0 NONE, 1 CSRW, 2 CSRS, 3 CSRC, 4 ECALL, 5 MRET, 6 SRET.
- `addr`  in  12  CSR address.
- `pc`  in  XLEN  PC of the committing instruction.
- `wdata`  in  XLEN  CSR write/set/clear operand.
- `irq_mtip`  in  1  level machine-timer interrupt request.
- `rdata`  out  XLEN  old CSR value; combinational; 0 unless `r_valid`.
- `r_valid`  out  1  `valid` and op is 1–3 and the access is legal.
- `illegal`  out  1  combinational; current access is illegal.
- `satp`  out  XLEN  current `satp`.
- `priv_o`  out  2  current privilege: 0 U, 1 S, 3 M.
- `trap_en`  out  1  registered one-cycle redirect pulse.
- `trap_pc`  out  XLEN  redirect target; valid while `trap_en` is high.

## Operation
- Implemented CSRs:
  - `sstatus` 0x100, `stvec` 0x105, `sscratch` 0x140, `sepc` 0x141, `scause` 0x142, `stval` 0x143, `satp` 0x180.
  - `mstatus` 0x300, `misa` 0x301, `medeleg` 0x302, `mie` 0x304, `mtvec` 0x305.
  - `mscratch` 0x340, `mepc` 0x341, `mcause` 0x342, `mtval` 0x343, `mip` 0x344.
  - `mcycle` 0xB00, `minstret` 0xB02, `cycle` 0xC00, `mhartid` 0xF14.
- `mstatus` writable fields: SIE[1], MIE[3], SPIE[5], MPIE[7], SPP[8], MPP[12:11]. All other bits read 0.
  - A write of MPP=2'b10 stores 0. With `HAS_S`=0, a write of MPP=1 stores 0.
- `sstatus` is a view of `mstatus` masked to SIE, SPIE and SPP.
- Read-only values:
  - `misa`: MXL=2 in bits [63:62], plus bits I(8), M(12), U(20), and S(18) when `HAS_S`=1. Writes are silently ignored.
  - `mip`: bit 7 = `irq_mtip`; all other bits 0.
- CSR access is illegal when any of the following holds:
  - the address is unimplemented;
  - `addr[9:8]` > `priv`;
  - op is 1–3 and `addr[11:10]`==2'b11 (this includes CSRS/CSRC with `wdata`=0).
- ECALL raises cause 8 (U), 9 (S) or 11 (M). MRET is illegal unless priv==M. SRET is illegal when priv==U.
- An illegal access raises cause 2 with tval=0. Nothing is written and `r_valid`=0.
- Exception entry with cause c:
  - Delegated to S when `HAS_S`, `medeleg[c]`=1 and priv≠M. Then:
    - `sepc`=pc, `scause`=c, `stval`=0;
    - SPP=priv[0], SPIE=SIE, SIE=0;
    - priv=S; `trap_pc`=`stvec` base.
  - Otherwise, to M:
    - `mepc`=pc, `mcause`=c, `mtval`=0;
    - MPP=priv, MPIE=MIE, MIE=0;
    - priv=M; `trap_pc`=`mtvec` base.
- Interrupt is taken when all hold: `valid`, `irq_mtip`, `mie[7]`, and (priv<M or MIE).
  - It has priority over `op`; the instruction is not executed.
  - `mcause`={1, 63'd7}, `mepc`=pc, MPP/MPIE/MIE handled as for an M trap. Interrupts are never delegated.
- Trap vector: base = `tvec[63:2]`<<2. If `tvec[0]`=1 and the trap is an interrupt, target = base + 4×cause.
- MRET: priv=MPP, MIE=MPIE, MPIE=1, MPP=U; `trap_pc`=`mepc`.
- SRET: priv={0,SPP}, SIE=SPIE, SPIE=1, SPP=0; `trap_pc`=`sepc`.
- `cycle` mirrors `mcycle`.
- Every input except `irq_mtip` is ignored when `valid`=0.

## Timing
- Reset values: priv=M; every CSR 0 except `misa` and `mhartid`; `trap_en`=0; `trap_pc`=0.
- `rdata`, `r_valid` and `illegal` reflect the state before the edge.
- All state updates occur at the next posedge.
- `trap_en`/`trap_pc` assert in the cycle after the trap, MRET or SRET, for exactly one cycle.
- The pipeline keeps `valid` low while `trap_en` is high.
- `mcycle` increments every cycle. A CSR write to it in the same cycle wins.
- `minstret` increments when `valid`, op is not ECALL, and no trap or illegal occurs. A CSR write to it wins.
- Both counters wrap from 2^64−1 to 0.
- Reset mid-operation clears everything asynchronously, including a pending `trap_en`.

## Test plan
- Reset, then read 0x301 -> `rdata`=0x8000_0000_0014_1100, `priv_o`=3, `trap_en`=0.
- CSRW 0x305=0x8000_0000, then ECALL at pc=0x100 in M -> one cycle later `trap_en`=1, `trap_pc`=0x8000_0000; `mcause`=11; `mepc`=0x100.
- MPP=0 and `mepc`=0x200, MRET -> `trap_pc`=0x200, `priv_o`=0. Then CSRW 0x300 in U -> `illegal`=1 and a trap with `mcause`=2.
- `medeleg`=0x100, `stvec`=0x4000, ECALL from U -> `trap_pc`=0x4000, `priv_o`=1, `scause`=8, `mcause` unchanged.
- `mtvec`=0x1001, `mie`=0x80, MIE=1, raise `irq_mtip` with `valid`=1 and op=CSRW -> `trap_pc`=0x101C, `mcause`=0x8000_0000_0000_0007, CSR not written.
- CSRW 0xB00=2^64−1 -> next cycle reads 0. CSRS 0xC00 with `wdata`=0 -> `illegal`=1.
